mem_arbiter: RTL and testbench

Shares the single unified memory port between the fetch stage and the memory stage (LW/SW) of the 16-bit pipelined core. Accepts level-held requests from both sides and grants one transaction at a time. Forwards each granted transaction to memory and holds it until memory signals ready, then returns data and a one-cycle completion pulse. Data accesses win by default; a starvation counter guarantees fetch progress. Fetch is blocked once the core halts.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/arb_starve_cnt.sv | 36 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } arb_state_e;

  // Decoder helper: returns {d_we, d_re} for an opcode
  function automatic logic [1:0] mem_op_req(input logic [3:0] op);
    return {op == OP_SW, op == OP_LW};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Unified memory port: the arbiter is the master, the memory is the slave.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_rdy
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants won while a fetch was waiting.
module arb_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat_c
);

  localparam int unsigned CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat_c = (cnt_q == CNT_W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and LW/SW,
// data first with a starvation bound so fetch always makes progress.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  mem_arbiter_if.master     mem,
  output logic              busy
);

  arb_state_e state_q, state_d;

  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              if_valid_q,  if_valid_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              d_valid_q,   d_valid_d;
  logic              busy_q,      busy_d;

  logic d_any_c;
  logic if_ok_c;
  logic grant_if_c;
  logic grant_d_c;
  logic starve_sat_c;

  // A requester is ignored during its own completion cycle
  assign d_any_c = (d_re | d_we) & ~d_valid_q;
  assign if_ok_c = if_req & ~if_valid_q & ~halt;

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_d_c & if_ok_c),
    .clr   (grant_if_c | ~if_req),
    .sat_c (starve_sat_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_if_c = 1'b0;
    grant_d_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_ok_c && (!d_any_c || starve_sat_c)) begin
          grant_if_c = 1'b1;
          state_d    = ST_BUSY_IF;
        end else if (d_any_c) begin
          grant_d_c = 1'b1;
          state_d   = ST_BUSY_D;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (mem.mem_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    busy_d      = (state_d != ST_IDLE);

    if (grant_if_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
    end else if (grant_d_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end

    if (state_q == ST_BUSY_IF && mem.mem_rdy) begin
      mem_en_d   = 1'b0;
      if_valid_d = 1'b1;
      if_rdata_d = mem.mem_rdata;
    end

    // Stores complete without disturbing the last load value
    if (state_q == ST_BUSY_D && mem.mem_rdy) begin
      mem_en_d  = 1'b0;
      d_valid_d = 1'b1;
      if (!mem_we_q) d_rdata_d = mem.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign mem.mem_en    = mem_en_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign if_valid      = if_valid_q;
  assign d_rdata       = d_rdata_q;
  assign d_valid       = d_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n, halt;
  logic        if_req, if_valid, d_re, d_we, d_valid, busy;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mif ();

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem(mif), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the port, the latched transaction, results
  int          owner = 0;   // 0 none, 1 fetch, 2 data
  int          starve = 0;
  bit          m_en = 0, m_we = 0, m_if_valid = 0, m_d_valid = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
  bit          if_rel = 0, d_rel = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ifv_prev, dv_prev, want_if, want_d;
    ifv_prev   = m_if_valid;
    dv_prev    = m_d_valid;
    m_if_valid = 0;
    m_d_valid  = 0;
    if (!rst_n) begin
      owner = 0; starve = 0; m_en = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
      return;
    end
    if (owner != 0) begin
      if (mif.mem_rdy) begin
        if (owner == 1) begin
          m_if_valid = 1; m_if_rdata = mif.mem_rdata;
        end else begin
          m_d_valid = 1;
          if (!m_we) m_d_rdata = mif.mem_rdata;
        end
        owner = 0; m_en = 0;
      end
    end else begin
      want_d  = (d_re || d_we) && !dv_prev;
      want_if = if_req && !ifv_prev && !halt;
      if (want_if && (!want_d || starve >= STARVE_MAX)) begin
        owner = 1; m_en = 1; m_we = 0; m_addr = if_addr; starve = 0;
      end else if (want_d) begin
        owner = 2; m_en = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        if (want_if && starve < STARVE_MAX) starve = starve + 1;
      end
    end
    if (!if_req) starve = 0;
  endtask

  task automatic check_model();
    check_eq("mem_en", mif.mem_en, m_en);
    check_eq("mem_we", mif.mem_we, m_we);
    check_eq("mem_addr", mif.mem_addr, m_addr);
    if (m_we) check_eq("mem_wdata", mif.mem_wdata, m_wdata);
    check_eq("if_valid", if_valid, m_if_valid);
    check_eq("d_valid", d_valid, m_d_valid);
    check_eq("if_rdata", if_rdata, m_if_rdata);
    check_eq("d_rdata", d_rdata, m_d_rdata);
    check_eq("busy", busy, owner != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drain();
    if_req = 0; d_re = 0; d_we = 0; halt = 0; mif.mem_rdy = 1;
    repeat (3) step();
    mif.mem_rdy = 0;
    step();
  endtask

  // Requesters hold through their completion cycle, then may change
  task automatic rand_inputs();
    int kind;
    rst_n         = ($urandom_range(0, 299) != 0);
    halt          = ($urandom_range(0, 5) == 0);
    mif.mem_rdy   = 1'($urandom_range(0, 1));
    mif.mem_rdata = 16'($urandom);
    if (m_if_valid) if_rel = 1;
    else if (if_rel || !if_req) begin
      if_rel  = 0;
      if_req  = 1'($urandom_range(0, 1));
      if_addr = 16'($urandom);
    end
    if (m_d_valid) d_rel = 1;
    else if (d_rel || !(d_re || d_we)) begin
      d_rel   = 0;
      kind    = $urandom_range(0, 3);
      d_re    = (kind == 1 || kind == 3);
      d_we    = (kind == 2 || kind == 3);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
    end
  endtask

  initial begin
    int   n_grant;
    logic prev_en;

    rst_n = 0; halt = 0; if_req = 1; if_addr = 16'h0040;
    d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mif.mem_rdy = 0; mif.mem_rdata = '0;

    // Reset held two edges with a pending fetch
    step(); step();
    check_eq("rst_mem_en", mif.mem_en, 0);
    check_eq("rst_mem_wdata", mif.mem_wdata, 0);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_busy", busy, 0);

    // Fetch alone, memory ready two cycles after mem_en
    rst_n = 1;
    step();
    check_eq("fetch_grant_en", mif.mem_en, 1);
    check_eq("fetch_grant_addr", mif.mem_addr, 16'h0040);
    step();
    check_eq("fetch_wait_en", mif.mem_en, 1);
    mif.mem_rdy = 1; mif.mem_rdata = 16'hB123;
    step();
    check_eq("fetch_valid", if_valid, 1);
    check_eq("fetch_rdata", if_rdata, 16'hB123);
    mif.mem_rdy = 0;
    step();
    check_eq("fetch_valid_once", if_valid, 0);
    check_eq("fetch_no_regrant", mif.mem_en, 0);
    if_req = 0;
    step();

    // Contention: data wins, fetch follows during the data valid cycle
    d_re = 1; d_addr = 16'h1000; if_req = 1; if_addr = 16'h0080;
    step();
    check_eq("cont_first_addr", mif.mem_addr, 16'h1000);
    mif.mem_rdy = 1; mif.mem_rdata = 16'h5A5A;
    step();
    check_eq("cont_d_valid", d_valid, 1);
    check_eq("cont_d_rdata", d_rdata, 16'h5A5A);
    mif.mem_rdy = 0;
    step();
    check_eq("cont_second_addr", mif.mem_addr, 16'h0080);
    check_eq("cont_second_en", mif.mem_en, 1);
    d_re = 0; mif.mem_rdy = 1; mif.mem_rdata = 16'h1234;
    step();
    check_eq("cont_if_rdata", if_rdata, 16'h1234);
    if_req = 0; mif.mem_rdy = 0;
    step();

    // Store: write payload held until ready, load data untouched
    d_we = 1; d_addr = 16'h2002; d_wdata = 16'hBEEF;
    step();
    check_eq("st_we", mif.mem_we, 1);
    check_eq("st_wdata", mif.mem_wdata, 16'hBEEF);
    step();
    check_eq("st_hold_wdata", mif.mem_wdata, 16'hBEEF);
    mif.mem_rdy = 1; mif.mem_rdata = 16'hDEAD;
    step();
    check_eq("st_d_valid", d_valid, 1);
    check_eq("st_d_rdata_kept", d_rdata, 16'h5A5A);
    d_we = 0; mif.mem_rdy = 0;
    step();

    // Starvation: halt masks fetch only in each data valid cycle
    if_req = 1; if_addr = 16'h0100; d_re = 1; d_addr = 16'h3000; mif.mem_rdy = 1;
    n_grant = 0; prev_en = 1'b0;
    for (int c = 0; c < 40 && n_grant < 5; c++) begin
      halt = m_d_valid;
      step();
      if (mif.mem_en && !prev_en) begin
        check_eq("starve_grant_addr", mif.mem_addr, (n_grant < 4) ? 16'h3000 : 16'h0100);
        n_grant++;
      end
      prev_en = mif.mem_en;
    end
    check_eq("starve_grants", n_grant, 5);
    drain();

    // Halt blocks new fetch, but an in-flight fetch completes
    halt = 1; if_req = 1; if_addr = 16'h0200;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("halt_no_grant", mif.mem_en, 0);
    end
    halt = 0;
    step();
    check_eq("unhalt_grant", mif.mem_addr, 16'h0200);
    halt = 1; mif.mem_rdy = 1; mif.mem_rdata = 16'h0F0F;
    step();
    check_eq("halt_inflight_valid", if_valid, 1);
    if_req = 0; halt = 0; mif.mem_rdy = 0;
    step();

    // Reset in the middle of a data read
    d_re = 1; d_addr = 16'h4000;
    step();
    check_eq("midrst_busy_before", busy, 1);
    rst_n = 0; mif.mem_rdy = 1;
    step();
    check_eq("midrst_mem_en", mif.mem_en, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_no_valid", d_valid, 0);
    rst_n = 1; d_re = 0; mif.mem_rdy = 0;
    step();
    check_eq("midrst_no_late_valid", d_valid, 0);

    // Randomized traffic
    if_rel = 0; d_rel = 0;
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
